// File: rtl/dmem_lsu.sv
// Byte/half/word data memory with fault detection and an RD_LAT-deep response pipeline.
// Define DMEM_CLEAR_ON_RESET_EN to zero the whole array with a sweep after every reset.
module dmem_lsu #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             oor;
  logic             fault;
  logic             accept;
  logic             wr_en;
  logic [3:0]       wmask;
  logic [31:0]      wdata_rep;
  logic [31:0]      rd_word;
  logic [15:0]      rd_shift;
  logic [31:0]      ld_ext;
  logic [31:0]      s1_data_d;
  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;

  assign idx    = req_addr[IDX_W+1:2];
  assign lane   = req_addr[1:0];
  assign oor    = (req_addr >> (IDX_W + 2)) != '0;
  assign fault  = (req_size == 2'b11) ||
                  (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                  oor;
  assign req_ready = !busy;
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_we && !fault;

  // Store data is replicated across lanes so the byte mask alone selects what lands.
  always_comb begin
    wmask     = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        wmask     = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wmask     = 4'b0011 << lane;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10:   wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
  end

  assign rd_word  = mem_q[idx];
  assign rd_shift = 16'(rd_word >> {lane, 3'b000});

  always_comb begin
    ld_ext = rd_word;
    case (req_size)
      2'b00:   ld_ext = req_unsigned ? {24'h0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_ext = req_unsigned ? {16'h0, rd_shift}
                                     : {{16{rd_shift[15]}}, rd_shift};
      default: ld_ext = rd_word;
    endcase
  end

  assign s1_data_d = (accept && !req_we && !fault) ? ld_ext : 32'h0;

`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign clr_idx = cnt_q;
  assign busy    = (state_q == S_CLEAR);
`else
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
  assign busy    = 1'b0;
`endif

  // Storage has no reset: contents survive rst unless the sweep clears them.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx] <= 32'h0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem_q[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

  logic [RD_LAT-1:0] v_q;
  logic [RD_LAT-1:0] f_q;
  logic [31:0]       d_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      f_q <= '0;
      for (int i = 0; i < RD_LAT; i++) d_q[i] <= 32'h0;
    end else begin
      v_q[0] <= accept;
      f_q[0] <= accept && fault;
      d_q[0] <= s1_data_d;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign rsp_valid = v_q[RD_LAT-1];
  assign rsp_fault = f_q[RD_LAT-1];
  assign rsp_rdata = d_q[RD_LAT-1];

endmodule
